tmds_channel_decoder: RTL and testbench



---
 rtl/tmds_channel_decoder.sv | 198 +++++++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder
//   Receive side of one TMDS lane. It takes unaligned 10-bit words from a
//   1:10 deserializer and finds the symbol boundary by hunting for control
//   tokens at each of the ten bit offsets. Every symbol is then decoded into
//   either pixel data (de=1) or control bits (de=0).
//
// Ports
//   clk           pixel clock, all logic on the rising edge
//   rst           synchronous active-high reset
//   raw_word      unaligned deserialized bits, [0] is the earliest bit
//   aligned       1 while the lane is LOCKED
//   bit_offset    current alignment offset, 0..9
//   data          decoded pixel byte, valid when de=1
//   de            1 = data symbol, 0 = control symbol
//   c0, c1        control bits; they hold their value through data periods
//   realign_count LOCKED->SEARCH count, saturating at 255
//                 (present only when TMDS_LOCK_STATS_EN is defined)
//
// Latency: raw_word is sampled on edge N, sym is registered on edge N+1,
// and data/de/c0/c1 are registered on edge N+2.
module tmds_channel_decoder #(
  parameter int LOCK_TOKENS    = 16,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] raw_word,
  output logic       aligned,
  output logic [3:0] bit_offset,
  output logic [7:0] data,
  output logic       de,
  output logic       c0,
  output logic       c1
`ifdef TMDS_LOCK_STATS_EN
  ,
  output logic [7:0] realign_count
`endif
);

  localparam int RW = $clog2(LOCK_TOKENS + 1);
  localparam int IW = $clog2(((LOSS_TIMEOUT > SEARCH_TIMEOUT) ? LOSS_TIMEOUT : SEARCH_TIMEOUT) + 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t         state_q;
  logic [RW-1:0]  run_cnt_q;
  logic [IW-1:0]  idle_cnt_q;
  logic [3:0]     bit_offset_q;
  logic           aligned_q;

  logic [9:0]     prev_word_q;
  logic [9:0]     sym_q, sym_d;
  logic [7:0]     data_q, data_d;
  logic           de_q, de_d;
  logic           c0_q, c0_d, c1_q, c1_d;

  logic [19:0]    win;
  logic           tok_hit;
  logic [1:0]     tok_c;
  logic [7:0]     t, dec;
  logic [RW-1:0]  run_inc;
  logic [IW-1:0]  idle_inc;
  logic [3:0]     offset_nxt;

  // Window selection and decode
  always_comb begin
    win   = {raw_word, prev_word_q};
    sym_d = win[bit_offset_q +: 10];

    tok_hit = 1'b1;
    tok_c   = 2'b00;
    case (sym_q)
      10'b1101010100: tok_c = 2'b00;
      10'b0010101011: tok_c = 2'b01;
      10'b0101010100: tok_c = 2'b10;
      10'b1010101011: tok_c = 2'b11;
      default:        tok_hit = 1'b0;
    endcase

    // Undo the optional inversion, then the XOR/XNOR transition chain.
    t      = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
    dec    = '0;
    dec[0] = t[0];
    for (int i = 1; i < 8; i++)
      dec[i] = sym_q[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);

    if (tok_hit) begin
      de_d   = 1'b0;
      data_d = 8'h00;
      c1_d   = tok_c[1];
      c0_d   = tok_c[0];
    end else begin
      de_d   = 1'b1;
      data_d = dec;
      c1_d   = c1_q;
      c0_d   = c0_q;
    end

    // Counters saturate rather than wrap.
    run_inc    = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + 1'b1;
    idle_inc   = (idle_cnt_q == '1) ? idle_cnt_q : idle_cnt_q + 1'b1;
    offset_nxt = (bit_offset_q == 4'd9) ? 4'd0 : bit_offset_q + 4'd1;
  end

  // Datapath pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_word_q <= '0;
      sym_q       <= '0;
      data_q      <= '0;
      de_q        <= 1'b0;
      c0_q        <= 1'b0;
      c1_q        <= 1'b0;
    end else begin
      prev_word_q <= raw_word;
      sym_q       <= sym_d;
      data_q      <= data_d;
      de_q        <= de_d;
      c0_q        <= c0_d;
      c1_q        <= c1_d;
    end
  end

  // Alignment FSM. The stale sym seen in the cycle right after an offset
  // change is counted like any other symbol.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SEARCH;
      run_cnt_q    <= '0;
      idle_cnt_q   <= '0;
      bit_offset_q <= '0;
      aligned_q    <= 1'b0;
    end else begin
      case (state_q)
        SEARCH: begin
          if (tok_hit) begin
            run_cnt_q  <= run_inc;
            idle_cnt_q <= '0;
            if (run_inc >= RW'(LOCK_TOKENS)) begin
              state_q   <= LOCKED;
              aligned_q <= 1'b1;
              run_cnt_q <= '0;
            end
          end else begin
            run_cnt_q  <= '0;
            idle_cnt_q <= idle_inc;
            if (idle_inc >= IW'(SEARCH_TIMEOUT - 1)) begin
              bit_offset_q <= offset_nxt;
              idle_cnt_q   <= '0;
            end
          end
        end
        LOCKED: begin
          if (tok_hit) begin
            idle_cnt_q <= '0;
          end else begin
            idle_cnt_q <= idle_inc;
            if (idle_inc >= IW'(LOSS_TIMEOUT - 1)) begin
              state_q      <= SEARCH;
              aligned_q    <= 1'b0;
              bit_offset_q <= offset_nxt;
              idle_cnt_q   <= '0;
              run_cnt_q    <= '0;
            end
          end
        end
        default: state_q <= SEARCH;
      endcase
    end
  end

`ifdef TMDS_LOCK_STATS_EN
  logic [7:0] realign_q, realign_d;
  logic       lock_lost;

  always_comb begin
    lock_lost = (state_q == LOCKED) && !tok_hit && (idle_inc >= IW'(LOSS_TIMEOUT - 1));
    realign_d = realign_q;
    if (lock_lost && realign_q != 8'hFF) realign_d = realign_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) realign_q <= '0;
    else     realign_q <= realign_d;
  end

  assign realign_count = realign_q;
`endif

  assign aligned    = aligned_q;
  assign bit_offset = bit_offset_q;
  assign data       = data_q;
  assign de         = de_q;
  assign c0         = c0_q;
  assign c1         = c1_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
module tb_tmds_channel_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] raw_word;
  logic       aligned;
  logic [3:0] bit_offset;
  logic [7:0] data;
  logic       de, c0, c1;
`ifdef TMDS_LOCK_STATS_EN
  logic [7:0] realign_count;
`endif

  tmds_channel_decoder dut (
    .clk(clk), .rst(rst), .raw_word(raw_word),
    .aligned(aligned), .bit_offset(bit_offset),
    .data(data), .de(de), .c0(c0), .c1(c1)
`ifdef TMDS_LOCK_STATS_EN
    , .realign_count(realign_count)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T11 = 10'b1010101011;

  int errs = 0;
  int checks = 0;

  // Scoreboard: {de, c1, c0, data}
  logic [10:0] exp_q[$];
  logic        chk_in = 1'b0;
  logic [2:0]  chk_pipe = '0;
  logic [1:0]  cur_c = 2'b00;

  // Output appears two edges after the sampling edge.
  always @(posedge clk) chk_pipe <= {chk_pipe[1:0], chk_in};

  always @(negedge clk) begin
    if (chk_pipe[2]) begin
      logic [10:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL sb_underflow: output seen with no expected entry");
      end else begin
        e = exp_q.pop_front();
        if ({de, c1, c0, data} !== e) begin
          errs++;
          $display("FAIL sb_out: got de=%b c1c0=%b%b data=%h, want de=%b c1c0=%b data=%h",
                   de, c1, c0, data, e[10], e[9:8], e[7:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference TMDS encoder for video data; inv selects the sym[9] polarity.
  function automatic logic [9:0] enc(input logic [7:0] d, input logic inv);
    int n1;
    logic xn;
    logic [8:0] q;
    n1 = $countones(d);
    xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~xn;
    return {inv, q[8], inv ? ~q[7:0] : q[7:0]};
  endfunction

  // Raw word for a repeating token stream whose boundary lies at offset o.
  function automatic logic [9:0] rot(input logic [9:0] tk, input int o);
    logic [19:0] w;
    w = {tk, tk};
    w = w >> ((10 - o) % 10);
    return w[9:0];
  endfunction

  task automatic send(input logic [9:0] w, input logic c);
    raw_word = w;
    chk_in   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send_tok(input logic [9:0] w, input logic [1:0] c);
    exp_q.push_back({1'b0, c, 8'h00});
    cur_c = c;
    send(w, 1'b1);
  endtask

  task automatic send_dat(input logic [7:0] b, input logic inv);
    exp_q.push_back({1'b1, cur_c, b});
    send(enc(b, inv), 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    chk_in = 1'b0;
    raw_word = '0;
    cur_c = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] bytes [4];
    int n;
    logic wrong;
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h10; bytes[3] = 8'hA5;

    // Reset values
    do_reset();
    check("rst_aligned", aligned, 0);
    check("rst_offset", bit_offset, 0);
    check("rst_data", data, 0);
    check("rst_de", de, 0);
    check("rst_c0", c0, 0);
    check("rst_c1", c1, 0);
`ifdef TMDS_LOCK_STATS_EN
    check("rst_realign", realign_count, 0);
`endif

    // Lock at offset 0: prev-word + sym register add two edges to 16 tokens.
    repeat (17) send_tok(T00, 2'b00);
    check("lock0_early", aligned, 0);
    send_tok(T00, 2'b00);
    check("lock0_aligned", aligned, 1);
    check("lock0_offset", bit_offset, 0);

    // Data symbols, both polarities; control bits hold at 00.
    for (int i = 0; i < 4; i++) begin
      send_dat(bytes[i], 1'b0);
      send_dat(bytes[i], 1'b1);
    end
    check("data_aligned", aligned, 1);

    // Alternating control tokens, then a data symbol holding 11.
    for (int i = 0; i < 8; i++) begin
      send_tok(T01, 2'b01);
      send_tok(T11, 2'b11);
    end
    check("alt_aligned", aligned, 1);
    send_dat(8'h5A, 1'b0);
    send_tok(T01, 2'b01);

    // Loss of lock after LOSS_TIMEOUT-1 non-token symbols.
    repeat (4096) send(enc(8'h10, 1'b0), 1'b0);
    check("loss_still_locked", aligned, 1);
    send(enc(8'h10, 1'b0), 1'b0);
    check("loss_aligned", aligned, 0);
    check("loss_offset", bit_offset, 1);
`ifdef TMDS_LOCK_STATS_EN
    check("loss_realign", realign_count, 1);
`endif

    // Search for a stream whose boundary is at offset 7.
    do_reset();
    n = 0;
    wrong = 1'b0;
    while (!aligned && n < 12000) begin
      send(rot(T00, 7), 1'b0);
      n++;
      if (n == 1100) check("search_step1", bit_offset, 1);
      if (aligned && bit_offset != 4'd7) wrong = 1'b1;
    end
    check("search7_locked", aligned, 1);
    check("search7_offset", bit_offset, 7);
    check("search7_no_false_lock", wrong, 0);
    check("search7_not_early", (n > 7000), 1);

    // Lock at offset 3, pulse rst mid-stream, then relock.
    do_reset();
    n = 0;
    while (!aligned && n < 6000) begin
      send(rot(T00, 3), 1'b0);
      n++;
    end
    check("lock3_aligned", aligned, 1);
    check("lock3_offset", bit_offset, 3);
    repeat (5) send(rot(T00, 3), 1'b0);
    rst = 1'b1;
    send(rot(T00, 3), 1'b0);
    rst = 1'b0;
    check("midrst_aligned", aligned, 0);
    check("midrst_offset", bit_offset, 0);
    check("midrst_de", de, 0);
    check("midrst_data", data, 0);
    n = 0;
    while (!aligned && n < 6000) begin
      send(rot(T00, 3), 1'b0);
      n++;
    end
    check("relock3_aligned", aligned, 1);
    check("relock3_offset", bit_offset, 3);

    repeat (4) @(posedge clk);
    check("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
